// File: rtl/control_barrido_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_barrido_display_pkg
//  Description : Shared types, constants and helpers for the 4-digit
//                7-segment scan controller.
//                - estado_t      : scan FSM states (dark gap / digit lit)
//                - DIGITO_BLANCO : code that the decoder renders as blank
//                - ANODOS_OFF    : active-low anode pattern with all digits off
//                - N_DIGITOS     : number of multiplexed digits
//  Revision    : 1.0 - initial release
// ============================================================================
package control_barrido_display_pkg;

    typedef enum logic [0:0] {
        APAGADO   = 1'b0,
        ENCENDIDO = 1'b1
    } estado_t;

    localparam logic [3:0] DIGITO_BLANCO = 4'hF;
    localparam logic [3:0] ANODOS_OFF    = 4'b1111;
    localparam int         N_DIGITOS     = 4;

    // Active-low anode pattern that lights only digit k.
    function automatic logic [3:0] anodo_activo(input logic [1:0] k);
        return ~(4'b0001 << k);
    endfunction

    // Code presented to the decoder for digit k of value v. With blanking
    // enabled, digits 3..1 go blank when they and every more-significant
    // digit are zero; digit 0 is always shown so a zero value reads "0".
    // Non-BCD nibbles pass through untouched (the decoder blanks them).
    function automatic logic [3:0] digito_visible(input logic [15:0] v,
                                                  input logic [1:0]  k,
                                                  input logic        ocultar);
        logic       z3;
        logic       z2;
        logic       z1;
        logic       blanco;
        logic [3:0] nib;
        z3 = (v[15:12] == 4'h0);
        z2 = (v[11:8]  == 4'h0);
        z1 = (v[7:4]   == 4'h0);
        case (k)
            2'd3: begin
                nib    = v[15:12];
                blanco = z3;
            end
            2'd2: begin
                nib    = v[11:8];
                blanco = z3 & z2;
            end
            2'd1: begin
                nib    = v[7:4];
                blanco = z3 & z2 & z1;
            end
            default: begin
                nib    = v[3:0];
                blanco = 1'b0;
            end
        endcase
        return (ocultar && blanco) ? DIGITO_BLANCO : nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_barrido_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_barrido_display_if
//  Description : Bus between the value source (vending-machine core / bench)
//                and the display scan controller.
//                  valor         - four BCD digits, [15:12] most significant
//                  carga         - load strobe for valor
//                  ocultar_ceros - enable leading-zero blanking
//                  digito        - code to the BCD-to-7-segment decoder
//                  anodo         - active-low digit enables
//                  fin_barrido   - pulse on the last cycle of a full scan
//                Modports: master = value source, slave = scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_barrido_display_if;
    import control_barrido_display_pkg::*;

    logic [4*N_DIGITOS-1:0] valor;
    logic                   carga;
    logic                   ocultar_ceros;
    logic [3:0]             digito;
    logic [N_DIGITOS-1:0]   anodo;
    logic                   fin_barrido;

    modport master (
        output valor,
        output carga,
        output ocultar_ceros,
        input  digito,
        input  anodo,
        input  fin_barrido
    );

    modport slave (
        input  valor,
        input  carga,
        input  ocultar_ceros,
        output digito,
        output anodo,
        output fin_barrido
    );

endinterface
`default_nettype wire

// File: rtl/control_barrido_display_divisor_barrido.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_barrido
//  Description : Slot timer for the display scan. Counts clk cycles within a
//                digit slot (0..DIV-1) and advances the digit index 0..3 on
//                each wrap.
//                Ports:
//                  clk    - system clock
//                  rst    - synchronous active-high reset
//                  cnt    - cycle position inside the current slot
//                  idx    - digit index of the current slot
//                  ultimo - high on the last cycle of a slot; the next edge
//                           is a slot entry
//  Revision    : 1.0 - initial release
// ============================================================================
module divisor_barrido #(
    parameter  int DIV = 50000,
    localparam int CW  = $clog2(DIV)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    output logic [CW-1:0]      cnt,
    output logic [1:0]         idx,
    output logic               ultimo
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign cnt    = r_cnt;
    assign idx    = r_idx;
    assign ultimo = (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/control_barrido_display.sv
`default_nettype none
// ============================================================================
//  Module      : control_barrido_display
//  Description : Time-multiplexed scan controller for a 4-digit common-anode
//                7-segment display, with a dark gap at the start of each slot
//                (anti-ghosting) and optional leading-zero blanking.
//                Ports:
//                  clk    - system clock, rising edge
//                  rst    - synchronous active-high reset
//                  barrido- slave side of control_barrido_display_if
//                           (valor/carga/ocultar_ceros in,
//                            digito/anodo/fin_barrido out, all registered)
//                Parameters:
//                  DIV  - clk cycles per digit slot (>= 2)
//                  DEAD - dark cycles at slot start (0 < DEAD < DIV)
//  Revision    : 1.0 - initial release
// ============================================================================
module control_barrido_display
    import control_barrido_display_pkg::*;
#(
    parameter  int DIV  = 50000,
    parameter  int DEAD = 16,
    localparam int CW   = $clog2(DIV)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    control_barrido_display_if.slave  barrido
);

    // Outputs are registered, so every decision is taken one cycle early
    // from the registered slot position: the register then changes on the
    // same edge that moves cnt into the new region.
    localparam logic [CW-1:0] CNT_PENULT = CW'(DIV - 2);
    localparam logic [CW-1:0] DEAD_M1    = CW'(DEAD - 1);

    logic [CW-1:0]          w_cnt;
    logic [1:0]             w_idx;
    logic                   w_ultimo;
    logic [1:0]             w_idx_sig;

    logic [4*N_DIGITOS-1:0] r_snapshot;
    estado_t                r_estado;
    logic [3:0]             r_anodo;
    logic [3:0]             r_digito;
    logic                   r_fin;

    divisor_barrido #(
        .DIV    (DIV)
    ) u_divisor (
        .clk    (clk),
        .rst    (rst),
        .cnt    (w_cnt),
        .idx    (w_idx),
        .ultimo (w_ultimo)
    );

    assign w_idx_sig = w_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapshot <= '0;
            r_estado   <= APAGADO;
            r_anodo    <= ANODOS_OFF;
            r_digito   <= DIGITO_BLANCO;
            r_fin      <= 1'b0;
        end else begin
            // A load on a slot-entry edge still lands here, but the entry
            // below reads the pre-edge snapshot, so that slot shows old data.
            if (barrido.carga) begin
                r_snapshot <= barrido.valor;
            end

            r_fin <= (w_idx == 2'd3) && (w_cnt == CNT_PENULT);

            if (w_ultimo) begin
                // Slot entry: go dark and latch the new digit so it is
                // stable long before its anode turns on.
                r_estado <= APAGADO;
                r_anodo  <= ANODOS_OFF;
                r_digito <= digito_visible(r_snapshot, w_idx_sig,
                                           barrido.ocultar_ceros);
            end else if ((r_estado == APAGADO) && (w_cnt == DEAD_M1)) begin
                r_estado <= ENCENDIDO;
                r_anodo  <= anodo_activo(w_idx);
            end
        end
    end

    assign barrido.anodo       = r_anodo;
    assign barrido.digito      = r_digito;
    assign barrido.fin_barrido = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_control_barrido_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_barrido_display
//  Description : Directed self-checking bench for control_barrido_display
//                with DIV=8, DEAD=2 (one full scan = 32 cycles). p tracks the
//                position in the scan (idx*8 + cnt); exp_dig holds the digit
//                expected in each slot, updated by hand at each step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_barrido_display;

    logic clk = 1'b0;
    logic rst;

    control_barrido_display_if bus ();

    control_barrido_display #(
        .DIV     (8),
        .DEAD    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .barrido (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         p     = 0;
    logic [3:0] exp_dig [4];

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] exp_anodo(input int pos);
        if ((pos % 8) < 2) return 4'b1111;
        case (pos / 8)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s p=%0d: observed=%h expected=%h", tag, p, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s p=%0d: observed=%b expected=%b", tag, p, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, checking every output against the scan model.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            p = (p + 1) % 32;
            chk4("anodo", bus.anodo, exp_anodo(p));
            chk4("digito", bus.digito, exp_dig[p / 8]);
            chk1("fin_barrido", bus.fin_barrido, p == 31);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.valor         = 16'h0000;
        bus.carga         = 1'b0;
        bus.ocultar_ceros = 1'b0;
        tick();
        tick();
        p = 0;
        chk4("reset_anodo", bus.anodo, 4'b1111);
        chk4("reset_digito", bus.digito, 4'hF);
        chk1("reset_fin", bus.fin_barrido, 1'b0);

        // Free run: slot 0 keeps the reset blank, later slots show snapshot 0.
        rst = 1'b0;
        exp_dig[0] = 4'hF; exp_dig[1] = 4'h0; exp_dig[2] = 4'h0; exp_dig[3] = 4'h0;
        run(31);

        // Load 1234 on a slot-entry edge: slot 0 still shows the old 0.
        exp_dig[0] = 4'h0;
        bus.valor = 16'h1234;
        bus.carga = 1'b1;
        run(1);
        bus.carga = 1'b0;
        exp_dig[1] = 4'h3; exp_dig[2] = 4'h2; exp_dig[3] = 4'h1;
        run(31);
        exp_dig[0] = 4'h4;
        run(8);

        // Mid-slot load (idx 1, cnt 4): slot 1 keeps 3, slot 2 shows 6.
        run(5);
        bus.valor = 16'h5678;
        bus.carga = 1'b1;
        run(1);
        bus.carga = 1'b0;
        exp_dig[2] = 4'h6; exp_dig[3] = 4'h5; exp_dig[0] = 4'h8;
        run(26);
        exp_dig[1] = 4'h7;
        run(8);

        // 0070 with blanking: F,F,7,0 for idx 3..0.
        bus.valor         = 16'h0070;
        bus.carga         = 1'b1;
        bus.ocultar_ceros = 1'b1;
        run(1);
        bus.carga = 1'b0;
        exp_dig[3] = 4'hF; exp_dig[0] = 4'h0; exp_dig[1] = 4'h7;
        run(8);
        exp_dig[2] = 4'hF;
        run(24);
        run(8);

        // Blanking off (sampled at slot entry): 0,0,7,0.
        bus.ocultar_ceros = 1'b0;
        exp_dig[0] = 4'h0; exp_dig[1] = 4'h7; exp_dig[2] = 4'h0;
        run(8);
        exp_dig[3] = 4'h0;
        run(32);

        // 0000 with blanking: F,F,F,0.
        bus.valor         = 16'h0000;
        bus.carga         = 1'b1;
        bus.ocultar_ceros = 1'b1;
        run(1);
        bus.carga = 1'b0;
        exp_dig[1] = 4'hF; exp_dig[2] = 4'hF; exp_dig[3] = 4'hF; exp_dig[0] = 4'h0;
        run(31);
        run(8);

        // Non-BCD digits pass through: D,C,B,A.
        bus.valor         = 16'hABCD;
        bus.carga         = 1'b1;
        bus.ocultar_ceros = 1'b0;
        run(1);
        bus.carga = 1'b0;
        exp_dig[2] = 4'hB; exp_dig[3] = 4'hA; exp_dig[0] = 4'hD;
        run(23);
        exp_dig[1] = 4'hC;
        run(16);

        // Reset at idx 2, cnt 5.
        run(5);
        rst = 1'b1;
        tick();
        p = 0;
        chk4("midreset_anodo", bus.anodo, 4'b1111);
        chk4("midreset_digito", bus.digito, 4'hF);
        chk1("midreset_fin", bus.fin_barrido, 1'b0);
        rst = 1'b0;
        exp_dig[0] = 4'hF; exp_dig[1] = 4'h0; exp_dig[2] = 4'h0; exp_dig[3] = 4'h0;
        run(31);
        exp_dig[0] = 4'h0;
        run(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
